// File: rtl/cheat_pgm_seq.sv
// cheat_pgm_seq: collects MCU cheat/hook configuration in a shadow bank and
// replays it into the cheat unit's pgm_idx/pgm_in/pgm_we port as one atomic
// sequence (mask off, dirty slots, mask on, flags). The replay starts only
// after the SNES has spent a run of bus cycles outside hook code.
// Optional feature: define CHEAT_PGM_READBACK_EN to add shadow and dirty-bit
// readback ports (mcu_rd_addr, mcu_rd_data, mcu_dirty).
module cheat_pgm_seq #(
   parameter int NUM_SLOTS    = 6,
   parameter int GUARD_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst,
`ifdef CHEAT_PGM_READBACK_EN
   input  logic [2:0]  mcu_rd_addr,
   output logic [31:0] mcu_rd_data,
   output logic [7:0]  mcu_dirty,
`endif
   input  logic        mcu_wr,
   input  logic [2:0]  mcu_addr,
   input  logic [31:0] mcu_data,
   input  logic        mcu_commit,
   input  logic        snes_cycle_start,
   input  logic        snescmd_unlock,
   output logic [2:0]  pgm_idx,
   output logic [31:0] pgm_in,
   output logic        pgm_we,
   output logic        busy,
   output logic        commit_done,
   output logic        wr_err
);

   localparam int         QW        = $clog2(GUARD_CYCLES + 1);
   localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);
   localparam logic [2:0] IDX_MASK  = 3'd6;
   localparam logic [2:0] IDX_FLAGS = 3'd7;
   localparam logic [QW-1:0] QLAST  = QW'(GUARD_CYCLES - 1);
   localparam logic [QW-1:0] QMAX   = QW'(GUARD_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_QUIET,
      S_MOFF,
      S_SLOT,
      S_MON,
      S_FLAG,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [QW-1:0]  qcnt_q, qcnt_d;
   logic [2:0]     sp_q, sp_d;
   logic [31:0]    shadow_q [8];
   logic [7:0]     dirty_q;
   logic           idle;
   logic           shadow_wr;
   logic           we_d;
   logic [2:0]     idx_d;
   logic [31:0]    in_d;
   logic           done_d;

   assign idle      = (state_q == S_IDLE);
   assign shadow_wr = mcu_wr & idle;
   assign busy      = ~idle;

   // Next-state and next-output decode; each state's programming write is
   // registered so idx/in/we appear together one clock later.
   always_comb begin
      state_d = state_q;
      qcnt_d  = qcnt_q;
      sp_d    = sp_q;
      we_d    = 1'b0;
      idx_d   = pgm_idx;
      in_d    = pgm_in;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mcu_commit) begin
               state_d = S_QUIET;
               qcnt_d  = '0;
            end
         end
         S_QUIET: begin
            if (snescmd_unlock) begin
               qcnt_d = '0;
            end else if (snes_cycle_start) begin
               if (qcnt_q == QLAST) begin
                  state_d = S_MOFF;
               end else if (qcnt_q != QMAX) begin
                  qcnt_d = qcnt_q + 1'b1;
               end
            end
         end
         S_MOFF: begin
            we_d    = 1'b1;
            idx_d   = IDX_MASK;
            in_d    = '0;
            sp_d    = '0;
            state_d = S_SLOT;
         end
         S_SLOT: begin
            if (dirty_q[sp_q]) begin
               we_d  = 1'b1;
               idx_d = sp_q;
               in_d  = shadow_q[sp_q];
            end
            if (sp_q == LAST_SLOT) begin
               state_d = S_MON;
            end else begin
               sp_d = sp_q + 3'd1;
            end
         end
         S_MON: begin
            we_d    = 1'b1;
            idx_d   = IDX_MASK;
            in_d    = shadow_q[IDX_MASK];
            state_d = S_FLAG;
         end
         S_FLAG: begin
            we_d    = 1'b1;
            idx_d   = IDX_FLAGS;
            in_d    = shadow_q[IDX_FLAGS];
            state_d = S_DONE;
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state, guard counter and slot pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         qcnt_q  <= '0;
         sp_q    <= '0;
      end else begin
         state_q <= state_d;
         qcnt_q  <= qcnt_d;
         sp_q    <= sp_d;
      end
   end

   // Registered programming port and completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pgm_we      <= 1'b0;
         pgm_idx     <= '0;
         pgm_in      <= '0;
         commit_done <= 1'b0;
      end else begin
         pgm_we      <= we_d;
         pgm_idx     <= idx_d;
         pgm_in      <= in_d;
         commit_done <= done_d;
      end
   end

   // Shadow bank: only accepts writes while idle; the mask entry keeps just
   // its six enable bits so the replayed mask word is already zero-extended.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            shadow_q[i] <= '0;
         end
      end else if (shadow_wr) begin
         if (mcu_addr == IDX_MASK) begin
            shadow_q[mcu_addr] <= {26'b0, mcu_data[5:0]};
         end else begin
            shadow_q[mcu_addr] <= mcu_data;
         end
      end
   end

   // Dirty bits: set by shadow writes, cleared as each slot is scanned and,
   // for mask/flags, when the commit finishes. Writes cannot collide with the
   // clears because writes are refused while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dirty_q <= '0;
      end else begin
         if (shadow_wr) begin
            dirty_q[mcu_addr] <= 1'b1;
         end
         if (state_q == S_SLOT) begin
            dirty_q[sp_q] <= 1'b0;
         end
         if (state_q == S_DONE) begin
            dirty_q[7:6] <= 2'b00;
         end
      end
   end

   // Sticky error for MCU traffic that arrives mid-commit; an idle flags write
   // acknowledges and clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_err <= 1'b0;
      end else if (!idle && (mcu_wr || mcu_commit)) begin
         wr_err <= 1'b1;
      end else if (shadow_wr && (mcu_addr == IDX_FLAGS)) begin
         wr_err <= 1'b0;
      end
   end

`ifdef CHEAT_PGM_READBACK_EN
   assign mcu_dirty = dirty_q;

   // Registered shadow readback, usable in any state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcu_rd_data <= '0;
      end else begin
         mcu_rd_data <= shadow_q[mcu_rd_addr];
      end
   end
`endif

endmodule

// File: tb/tb_cheat_pgm_seq.sv
// tb_cheat_pgm_seq: table-driven commit scenarios plus hand-written sequences
// for the quiet guard, busy-time errors, mid-commit reset and readback.
module tb_cheat_pgm_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        mcu_wr;
   logic [2:0]  mcu_addr;
   logic [31:0] mcu_data;
   logic        mcu_commit;
   logic        snes_cycle_start;
   logic        snescmd_unlock;
   logic [2:0]  pgm_idx;
   logic [31:0] pgm_in;
   logic        pgm_we;
   logic        busy;
   logic        commit_done;
   logic        wr_err;
`ifdef CHEAT_PGM_READBACK_EN
   logic [2:0]  mcu_rd_addr;
   logic [31:0] mcu_rd_data;
   logic [7:0]  mcu_dirty;
`endif

   always #5 clk = ~clk;

   cheat_pgm_seq #(.NUM_SLOTS(6), .GUARD_CYCLES(8)) dut (
      .clk              (clk),
      .rst              (rst),
`ifdef CHEAT_PGM_READBACK_EN
      .mcu_rd_addr      (mcu_rd_addr),
      .mcu_rd_data      (mcu_rd_data),
      .mcu_dirty        (mcu_dirty),
`endif
      .mcu_wr           (mcu_wr),
      .mcu_addr         (mcu_addr),
      .mcu_data         (mcu_data),
      .mcu_commit       (mcu_commit),
      .snes_cycle_start (snes_cycle_start),
      .snescmd_unlock   (snescmd_unlock),
      .pgm_idx          (pgm_idx),
      .pgm_in           (pgm_in),
      .pgm_we           (pgm_we),
      .busy             (busy),
      .commit_done      (commit_done),
      .wr_err           (wr_err)
   );

   typedef struct {
      string       name;
      logic [5:0]  slot_sel;
      logic [31:0] slot_base;
      logic [31:0] mask_word;
      logic [31:0] flags_word;
      int          exp_pulses;
   } vec_t;

   vec_t        vecs [5];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   logic [2:0]  cap_idx [$];
   logic [31:0] cap_in [$];
   int          cap_cyc [$];
   logic [2:0]  exp_idx [$];
   logic [31:0] exp_in [$];
   int          exp_off [$];
   logic [31:0] model_shadow [8];
   logic [7:0]  model_dirty;

   // Free-running cycle count used to time-stamp captured writes.
   always @(posedge clk) cyc <= cyc + 1;

   // Capture every programming write and completion pulse away from the edge.
   always @(negedge clk) begin
      if (pgm_we === 1'b1) begin
         cap_idx.push_back(pgm_idx);
         cap_in.push_back(pgm_in);
         cap_cyc.push_back(cyc);
      end
      if (commit_done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   // Hard time limit so the bench always ends.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string what, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %08h, expected %08h", what, got, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 8; i++) model_shadow[i] = '0;
      model_dirty = '0;
   endtask

   task automatic mcuWrite(input logic [2:0] addr, input logic [31:0] data);
      mcu_addr = addr;
      mcu_data = data;
      mcu_wr   = 1'b1;
      tick();
      mcu_wr   = 1'b0;
      model_shadow[addr] = (addr == 3'd6) ? {26'b0, data[5:0]} : data;
      model_dirty[addr]  = 1'b1;
   endtask

   task automatic pulseStarts(input int n);
      for (int i = 0; i < n; i++) begin
         snes_cycle_start = 1'b1;
         tick();
         snes_cycle_start = 1'b0;
         tick();
      end
   endtask

   // Expected replay from the bench's own shadow model: mask off, dirty
   // slots ascending one per clock, mask on, flags, with offsets from MOFF.
   task automatic buildExpected();
      exp_idx.delete();
      exp_in.delete();
      exp_off.delete();
      exp_idx.push_back(3'd6); exp_in.push_back(32'h0); exp_off.push_back(0);
      for (int i = 0; i < 6; i++) begin
         if (model_dirty[i]) begin
            exp_idx.push_back(3'(i));
            exp_in.push_back(model_shadow[i]);
            exp_off.push_back(1 + i);
         end
      end
      exp_idx.push_back(3'd6); exp_in.push_back(model_shadow[6]); exp_off.push_back(7);
      exp_idx.push_back(3'd7); exp_in.push_back(model_shadow[7]); exp_off.push_back(8);
      model_dirty = '0;
   endtask

   task automatic startCommit();
      cap_idx.delete();
      cap_in.delete();
      cap_cyc.delete();
      done_cnt   = 0;
      mcu_commit = 1'b1;
      tick();
      mcu_commit = 1'b0;
   endtask

   task automatic waitDone(input string name);
      int k = 0;
      while (done_cnt == 0 && k < 80) begin
         tick();
         k++;
      end
      checkOutput({name, " commit_done seen"}, (done_cnt > 0) ? 32'd1 : 32'd0, 32'd1);
      tick();
   endtask

   task automatic compareSequence(input string name);
      checkOutput({name, " pulse count"}, 32'(cap_idx.size()), 32'(exp_idx.size()));
      for (int i = 0; i < exp_idx.size() && i < cap_idx.size(); i++) begin
         checkOutput($sformatf("%s write%0d idx", name, i), {29'b0, cap_idx[i]}, {29'b0, exp_idx[i]});
         checkOutput($sformatf("%s write%0d in", name, i), cap_in[i], exp_in[i]);
         checkOutput($sformatf("%s write%0d clk", name, i), 32'(cap_cyc[i] - cap_cyc[0]), 32'(exp_off[i]));
      end
      if (cap_cyc.size() > 0) begin
         checkOutput({name, " done clk"}, 32'(done_cyc - cap_cyc[0]), 32'd9);
      end
      checkOutput({name, " done pulses"}, 32'(done_cnt), 32'd1);
      checkOutput({name, " idle busy"}, {31'b0, busy}, 32'd0);
      checkOutput({name, " idle pgm_we"}, {31'b0, pgm_we}, 32'd0);
      checkOutput({name, " held idx"}, {29'b0, pgm_idx}, 32'd7);
      checkOutput({name, " held in"}, pgm_in, model_shadow[7]);
   endtask

   task automatic runCommit(input string name);
      buildExpected();
      startCommit();
      checkOutput({name, " busy in quiet"}, {31'b0, busy}, 32'd1);
      pulseStarts(8);
      waitDone(name);
      compareSequence(name);
   endtask

   task automatic applyStimulus(input vec_t v);
      for (int i = 0; i < 6; i++) begin
         if (v.slot_sel[i]) mcuWrite(3'(i), v.slot_base + 32'(i));
      end
      mcuWrite(3'd6, v.mask_word);
      mcuWrite(3'd7, v.flags_word);
      runCommit(v.name);
      checkOutput({v.name, " table pulses"}, 32'(cap_idx.size()), 32'(v.exp_pulses));
      checkOutput({v.name, " wr_err"}, {31'b0, wr_err}, 32'd0);
   endtask

   initial begin
      int k;
      vecs[0] = '{"slot2 only",  6'b000100, 32'h00FFEA0E, 32'hFFFFFFC4, 32'h00000001, 4};
      vecs[1] = '{"slots 0+5",   6'b100001, 32'h80001000, 32'h0000003F, 32'h00000102, 5};
      vecs[2] = '{"no dirty",    6'b000000, 32'h00000000, 32'h00000000, 32'hABCD0000, 3};
      vecs[3] = '{"all slots",   6'b111111, 32'h11223300, 32'h0000002A, 32'h00003F3F, 9};
      vecs[4] = '{"slots 1+3",   6'b001010, 32'hC0DE0000, 32'h0000000A, 32'hFFFFFFFF, 5};

      rst = 1'b1;
      mcu_wr = 1'b0;
      mcu_addr = '0;
      mcu_data = '0;
      mcu_commit = 1'b0;
      snes_cycle_start = 1'b0;
      snescmd_unlock = 1'b0;
`ifdef CHEAT_PGM_READBACK_EN
      mcu_rd_addr = '0;
`endif
      modelReset();
      repeat (3) tick();
      checkOutput("reset pgm_we", {31'b0, pgm_we}, 32'd0);
      checkOutput("reset pgm_idx", {29'b0, pgm_idx}, 32'd0);
      checkOutput("reset pgm_in", pgm_in, 32'd0);
      checkOutput("reset busy", {31'b0, busy}, 32'd0);
      checkOutput("reset commit_done", {31'b0, commit_done}, 32'd0);
      checkOutput("reset wr_err", {31'b0, wr_err}, 32'd0);
`ifdef CHEAT_PGM_READBACK_EN
      checkOutput("reset rd_data", mcu_rd_data, 32'd0);
      checkOutput("reset dirty", {24'b0, mcu_dirty}, 32'd0);
`endif
      rst = 1'b0;
      tick();

      // Table of commit scenarios.
      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v]);
      end

      // Quiet guard: unlock held, then a run of four broken by an unlock start.
      $display("[TB] guard sequence");
      mcuWrite(3'd3, 32'h00C0FFEE);
      buildExpected();
      startCommit();
      snescmd_unlock = 1'b1;
      pulseStarts(20);
      snescmd_unlock = 1'b0;
      pulseStarts(4);
      snescmd_unlock = 1'b1;
      pulseStarts(1);
      snescmd_unlock = 1'b0;
      pulseStarts(7);
      repeat (3) tick();
      checkOutput("guard no early pgm_we", 32'(cap_idx.size()), 32'd0);
      checkOutput("guard still busy", {31'b0, busy}, 32'd1);
      pulseStarts(1);
      k = 0;
      while (cap_idx.size() == 0 && k < 6) begin
         tick();
         k++;
      end
      checkOutput("guard release latency", 32'(k), 32'd1);
      snescmd_unlock = 1'b1;
      waitDone("guard");
      compareSequence("guard");
      snescmd_unlock = 1'b0;

      // MCU write during SLOT is dropped and flagged.
      $display("[TB] busy write sequence");
      buildExpected();
      startCommit();
      pulseStarts(8);
      mcu_addr = 3'd0;
      mcu_data = 32'hDEADBEEF;
      mcu_wr   = 1'b1;
      tick();
      mcu_wr   = 1'b0;
      checkOutput("busy write wr_err", {31'b0, wr_err}, 32'd1);
      waitDone("busy write");
      compareSequence("busy write");
      checkOutput("wr_err sticky", {31'b0, wr_err}, 32'd1);
`ifdef CHEAT_PGM_READBACK_EN
      mcu_rd_addr = 3'd0;
      tick();
      checkOutput("slot0 unchanged", mcu_rd_data, model_shadow[0]);
`endif
      runCommit("after dropped write");
      mcuWrite(3'd7, 32'h00003F00);
      checkOutput("wr_err cleared", {31'b0, wr_err}, 32'd0);

      // Second commit while busy is ignored but flagged.
      buildExpected();
      startCommit();
      mcu_commit = 1'b1;
      tick();
      mcu_commit = 1'b0;
      checkOutput("busy commit wr_err", {31'b0, wr_err}, 32'd1);
      pulseStarts(8);
      waitDone("busy commit");
      compareSequence("busy commit");
      mcuWrite(3'd7, 32'h00000000);
      checkOutput("wr_err cleared again", {31'b0, wr_err}, 32'd0);

      // Reset in SLOT at sp=3 aborts the replay and clears the shadow bank.
      $display("[TB] mid-commit reset");
      for (int i = 0; i < 6; i++) mcuWrite(3'(i), 32'h5A5A0000 + 32'(i));
      mcuWrite(3'd6, 32'h00000015);
      startCommit();
      pulseStarts(8);
      repeat (3) tick();
      checkOutput("pre-reset pgm_we", {31'b0, pgm_we}, 32'd1);
      checkOutput("pre-reset idx", {29'b0, pgm_idx}, 32'd2);
      rst = 1'b1;
      #1;
      checkOutput("abort pgm_we", {31'b0, pgm_we}, 32'd0);
      checkOutput("abort busy", {31'b0, busy}, 32'd0);
      checkOutput("abort idx", {29'b0, pgm_idx}, 32'd0);
      checkOutput("abort in", pgm_in, 32'd0);
      cap_idx.delete();
      cap_in.delete();
      cap_cyc.delete();
      tick();
      rst = 1'b0;
      modelReset();
      repeat (2) tick();
      checkOutput("abort no more writes", 32'(cap_idx.size()), 32'd0);
`ifdef CHEAT_PGM_READBACK_EN
      mcu_rd_addr = 3'd3;
      tick();
      checkOutput("shadow cleared", mcu_rd_data, 32'd0);
`endif
      runCommit("post-reset");

`ifdef CHEAT_PGM_READBACK_EN
      // Readback latency and dirty visibility.
      $display("[TB] readback");
      mcuWrite(3'd5, 32'h0BADF00D);
      mcuWrite(3'd4, 32'h12345678);
      mcu_rd_addr = 3'd5;
      tick();
      mcu_rd_addr = 3'd4;
      #1;
      checkOutput("readback old value", mcu_rd_data, 32'h0BADF00D);
      tick();
      checkOutput("readback slot4", mcu_rd_data, 32'h12345678);
      checkOutput("dirty4 before commit", {31'b0, mcu_dirty[4]}, 32'd1);
      runCommit("readback commit");
      checkOutput("dirty after commit", {24'b0, mcu_dirty}, 32'd0);
      checkOutput("readback after commit", mcu_rd_data, 32'h12345678);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
